dirty_sector_tracker: RTL and testbench
=======================================

// Module: dirty_sector_tracker
// PURPOSE
//  Per-track dirty-sector bitmap with an integrated write-back scanner. The sector
//  write path marks sectors dirty or clean. On request, a round-robin scanner offers
//  each dirty sector to the write-back engine over a valid/ready handshake and clears
//  the sector on acceptance. Sits between the sector buffer write path and the SD
//  write-back engine.
// PARAMETERS
//  NUM_SECTORS  64                         sectors tracked (>=2)
//  SADDR_W      $clog2(NUM_SECTORS)        sector address width
//  CNT_W        $clog2(NUM_SECTORS+1)      dirty-count width
// PORTS
//  clk           in   1            single clock, all logic on rising edge
//  reset         in   1            synchronous, active-high
//  en            in   1            write-port enable
//  saddr         in   SADDR_W      write-port sector address
//  d             in   1            1 = mark dirty, 0 = mark clean
//  flush_req     in   1            start a flush pass; 1-cycle pulse, ignored unless IDLE
//  wb_ready      in   1            write-back engine accepts the offered sector
//  wb_valid      out  1            sector offer valid
//  wb_sector     out  SADDR_W      offered sector number
//  flush_busy    out  1            high in SCAN or OFFER
//  flush_done    out  1            1-cycle pulse when a pass finds no dirty sector
//  dirty_sectors out  NUM_SECTORS  registered bitmap
//  dirty_count   out  CNT_W        registered popcount of dirty_sectors
//  all_clean     out  1            dirty_sectors == 0 (combinational from the register)
// BEHAVIOUR
//  - Reset (any state, including mid-flush): bitmap=0, dirty_count=0, scan ptr=0,
//    state=IDLE, wb_valid=0, wb_sector=0, flush_done=0, flush_busy=0, all_clean=1.
//  - Write port: with en=1, bit saddr takes the value d at the next edge.
//    saddr >= NUM_SECTORS is ignored. dirty_count tracks the bitmap in the same cycle.
//  - FSM IDLE -> SCAN on flush_req.
//  - SCAN, one cycle: find the first dirty bit at index >= ptr, wrapping modulo
//    NUM_SECTORS.
//    - Found: wb_sector=index, wb_valid=1, go to OFFER.
//    - None: pulse flush_done, go to IDLE.
//  - OFFER: wb_valid and wb_sector are held stable until wb_ready=1.
//    - On the accept edge: clear the bit, set ptr=(wb_sector+1) mod NUM_SECTORS,
//      wb_valid=0, go to SCAN.
//    - A write-port clear of the offered sector does not withdraw the offer.
//  - Simultaneous accept and write-port set of the offered sector: the write wins and
//    the bit stays dirty (new data pending). It is picked up again on the next wrap.
//  - Simultaneous accept and a write port hitting a different sector: both apply.
//    dirty_count nets the change (+1, -1, 0 or -2 as applicable).
//  - Latency:
//    - flush_req -> first wb_valid: 2 edges.
//    - accept -> next wb_valid: 2 edges (one SCAN cycle).
//  - Sectors dirtied during a pass are offered in the same pass if ahead of ptr.
//    flush_done fires only after a SCAN sees an all-clean bitmap.
//  - ptr persists across passes; it is not reset by flush_req.
// STRUCTURE
//  - Shared pkg fpgahawk_disk_pkg:
//    - typedef enum logic[1:0] {FL_IDLE, FL_SCAN, FL_OFFER} flush_state_t.
//    - Default NUM_SECTORS localparam.
//  - Sub-module rr_find_first #(N): rotating priority encoder.
//    - Inputs: mask[N], ptr.
//    - Outputs: found, idx.
//    - Rotate, then leading-one from the LSB, then un-rotate; purely combinational.
//  - Top holds the bitmap, counter and FSM.
// TESTING  (NUM_SECTORS=64)
//  1. Reset, then write en=1,d=1 to saddr 3, 0, 63 on successive edges
//     -> dirty_sectors=64'h8000000000000009, dirty_count=3, all_clean=0.
//  2. With bits {3,0,63} set: flush_req, wb_ready=1 constantly
//     -> offers 0, 3, 63 in order (2 edges apart), then flush_done.
//     Afterwards all_clean=1 and dirty_count=0.
//  3. Backpressure: bit 5 set, flush_req, wb_ready=0 for 10 cycles
//     -> wb_valid=1 and wb_sector=5 stable throughout.
//     Raise wb_ready -> bit 5 clears.
//  4. Collision: offering sector 7, assert en=1,d=1,saddr=7 on the accept edge
//     -> bit 7 remains set, dirty_count unchanged.
//     Sector 7 is re-offered after wrap and the pass ends only when it is clean.
//  5. Wrap: after a pass ending at ptr=62, set bits 61 and 2 and flush
//     -> offer order is 2 then 61.
//  6. Reset mid-OFFER with bits {1,9,40} set
//     -> next cycle wb_valid=0, flush_busy=0, dirty_sectors=0, all_clean=1.
//     A subsequent flush_req yields flush_done with no offers.

Source files
------------

// File: rtl/fpgahawk_disk_pkg.sv
// Shared types and defaults for the disk-side blocks (sector tracking, write-back).
package fpgahawk_disk_pkg;

    typedef enum logic [1:0] {
        FL_IDLE,
        FL_SCAN,
        FL_OFFER
    } flush_state_t;

    localparam int unsigned DEFAULT_NUM_SECTORS = 64;

endpackage : fpgahawk_disk_pkg

// File: rtl/dirty_sector_tracker_rr_find_first.sv
// Rotating priority encoder: first set bit of mask at or after ptr, wrapping modulo N.
module rr_find_first #(
    parameter int unsigned N = 64,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0] rot;
    logic [W-1:0] off;
    logic [W:0]   sum;

    // Rotate so ptr sits at bit 0, pick the lowest set bit, then map back to an absolute index.
    always_comb begin
        rot   = N'({mask, mask} >> ptr);
        found = 1'b0;
        off   = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (rot[i-1]) begin
                found = 1'b1;
                off   = W'(i - 1);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
        end
        idx = sum[W-1:0];
    end

endmodule : rr_find_first

// File: rtl/dirty_sector_tracker.sv
// Dirty-sector bitmap with popcount and a round-robin write-back scanner.
module dirty_sector_tracker
    import fpgahawk_disk_pkg::*;
#(
    parameter int unsigned NUM_SECTORS = DEFAULT_NUM_SECTORS,
    parameter int unsigned SADDR_W     = $clog2(NUM_SECTORS),
    parameter int unsigned CNT_W       = $clog2(NUM_SECTORS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [SADDR_W-1:0]     saddr,
    input  logic                   d,
    input  logic                   flush_req,
    input  logic                   wb_ready,
    output logic                   wb_valid,
    output logic [SADDR_W-1:0]     wb_sector,
    output logic                   flush_busy,
    output logic                   flush_done,
    output logic [NUM_SECTORS-1:0] dirty_sectors,
    output logic [CNT_W-1:0]       dirty_count,
    output logic                   all_clean
);

    flush_state_t           state_q;
    logic [NUM_SECTORS-1:0] bitmap_q, bitmap_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [SADDR_W-1:0]     ptr_q;
    logic [SADDR_W-1:0]     wb_sector_q;
    logic                   wb_valid_q;
    logic                   flush_done_q;

    logic                   accept;
    logic                   wr_ok;
    logic                   hit_found;
    logic [SADDR_W-1:0]     hit_idx;

    assign accept = (state_q == FL_OFFER) && wb_ready;
    assign wr_ok  = en && ({1'b0, saddr} < (SADDR_W+1)'(NUM_SECTORS));

    rr_find_first #(
        .N (NUM_SECTORS),
        .W (SADDR_W)
    ) u_find (
        .mask  (bitmap_q),
        .ptr   (ptr_q),
        .found (hit_found),
        .idx   (hit_idx)
    );

    // Next bitmap: accept clears the offered bit, then the write port overrides (write wins).
    always_comb begin
        bitmap_d = bitmap_q;
        if (accept) begin
            bitmap_d[wb_sector_q] = 1'b0;
        end
        if (wr_ok) begin
            bitmap_d[saddr] = d;
        end
        count_d = '0;
        for (int unsigned i = 0; i < NUM_SECTORS; i++) begin
            count_d = count_d + CNT_W'(bitmap_d[i]);
        end
    end

    // Bitmap and its popcount register, updated together so the count never lags.
    always_ff @(posedge clk) begin
        if (reset) begin
            bitmap_q <= '0;
            count_q  <= '0;
        end else begin
            bitmap_q <= bitmap_d;
            count_q  <= count_d;
        end
    end

    // Flush FSM: scan for the next dirty sector, hold the offer until accepted, repeat until clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FL_IDLE;
            ptr_q        <= '0;
            wb_sector_q  <= '0;
            wb_valid_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                FL_IDLE: begin
                    if (flush_req) begin
                        state_q <= FL_SCAN;
                    end
                end
                FL_SCAN: begin
                    if (hit_found) begin
                        wb_sector_q <= hit_idx;
                        wb_valid_q  <= 1'b1;
                        state_q     <= FL_OFFER;
                    end else begin
                        flush_done_q <= 1'b1;
                        state_q      <= FL_IDLE;
                    end
                end
                FL_OFFER: begin
                    if (wb_ready) begin
                        wb_valid_q <= 1'b0;
                        ptr_q      <= (wb_sector_q == SADDR_W'(NUM_SECTORS - 1)) ?
                                      '0 : wb_sector_q + 1'b1;
                        state_q    <= FL_SCAN;
                    end
                end
                default: begin
                    state_q <= FL_IDLE;
                end
            endcase
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_sector     = wb_sector_q;
    assign flush_busy    = (state_q != FL_IDLE);
    assign flush_done    = flush_done_q;
    assign dirty_sectors = bitmap_q;
    assign dirty_count   = count_q;
    assign all_clean     = (bitmap_q == '0);

endmodule : dirty_sector_tracker

// File: tb/tb_dirty_sector_tracker.sv
// Directed bench for dirty_sector_tracker with NUM_SECTORS=64.
module tb_dirty_sector_tracker;

    localparam int unsigned NS = 64;
    localparam int unsigned SW = 6;
    localparam int unsigned CW = 7;

    logic          clk;
    logic          reset;
    logic          en;
    logic [SW-1:0] saddr;
    logic          d;
    logic          flush_req;
    logic          wb_ready;
    logic          wb_valid;
    logic [SW-1:0] wb_sector;
    logic          flush_busy;
    logic          flush_done;
    logic [NS-1:0] dirty_sectors;
    logic [CW-1:0] dirty_count;
    logic          all_clean;

    int n_checks = 0;
    int n_errors = 0;

    dirty_sector_tracker #(
        .NUM_SECTORS (NS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .saddr         (saddr),
        .d             (d),
        .flush_req     (flush_req),
        .wb_ready      (wb_ready),
        .wb_valid      (wb_valid),
        .wb_sector     (wb_sector),
        .flush_busy    (flush_busy),
        .flush_done    (flush_done),
        .dirty_sectors (dirty_sectors),
        .dirty_count   (dirty_count),
        .all_clean     (all_clean)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sector(input int unsigned a, input logic val);
        en    = 1'b1;
        saddr = SW'(a);
        d     = val;
        step();
        en    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; en = 1'b0; saddr = '0; d = 1'b0; flush_req = 1'b0; wb_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_bitmap", dirty_sectors, 64'h0);
        check("rst_count", dirty_count, 0);
        check("rst_clean", all_clean, 1);
        check("rst_valid", wb_valid, 0);
        check("rst_sector", wb_sector, 0);
        check("rst_busy", flush_busy, 0);
        check("rst_done", flush_done, 0);

        // 1. writes
        write_sector(3, 1); write_sector(0, 1); write_sector(63, 1);
        check("t1_bitmap", dirty_sectors, 64'h8000000000000009);
        check("t1_count", dirty_count, 3);
        check("t1_clean", all_clean, 0);

        // 2. full pass with ready always high
        flush_req = 1'b1; wb_ready = 1'b1;
        step(); flush_req = 1'b0;
        check("t2_busy", flush_busy, 1);
        check("t2_nov", wb_valid, 0);
        step();
        check("t2_v0", wb_valid, 1);
        check("t2_s0", wb_sector, 0);
        step();
        check("t2_gap", wb_valid, 0);
        check("t2_cnt2", dirty_count, 2);
        step();
        check("t2_s3", wb_sector, 3);
        check("t2_v3", wb_valid, 1);
        step(); step();
        check("t2_s63", wb_sector, 63);
        check("t2_v63", wb_valid, 1);
        step();
        check("t2_nodone", flush_done, 0);
        step();
        check("t2_done", flush_done, 1);
        check("t2_idle", flush_busy, 0);
        check("t2_clean", all_clean, 1);
        check("t2_count", dirty_count, 0);
        wb_ready = 1'b0;
        step();
        check("t2_pulse", flush_done, 0);

        // 3. backpressure
        write_sector(5, 1);
        flush_req = 1'b1; step(); flush_req = 1'b0; step();
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_v", wb_valid, 1);
            check("t3_hold_s", wb_sector, 5);
            step();
        end
        wb_ready = 1'b1; step();
        check("t3_cleared", dirty_sectors, 64'h0);
        check("t3_v", wb_valid, 0);
        wb_ready = 1'b0; step();
        check("t3_done", flush_done, 1);

        // 4. collision: re-dirty on the accept edge
        write_sector(7, 1);
        flush_req = 1'b1; step(); flush_req = 1'b0; step();
        check("t4_s7", wb_sector, 7);
        check("t4_cnt", dirty_count, 1);
        wb_ready = 1'b1; en = 1'b1; saddr = 7; d = 1'b1;
        step();
        en = 1'b0; wb_ready = 1'b0;
        check("t4_keep", dirty_sectors, 64'h80);
        check("t4_cnt_keep", dirty_count, 1);
        step();
        check("t4_reoffer_v", wb_valid, 1);
        check("t4_reoffer_s", wb_sector, 7);
        check("t4_nodone", flush_done, 0);
        wb_ready = 1'b1; step(); wb_ready = 1'b0; step();
        check("t4_done", flush_done, 1);
        check("t4_clean", all_clean, 1);

        // 5. wrap: leave ptr at 62, then 2 must precede 61
        write_sector(61, 1);
        flush_req = 1'b1; wb_ready = 1'b1; step(); flush_req = 1'b0; step();
        check("t5_pre61", wb_sector, 61);
        step(); step();
        check("t5_pre_done", flush_done, 1);
        write_sector(61, 1); write_sector(2, 1);
        flush_req = 1'b1; step(); flush_req = 1'b0; step();
        check("t5_first", wb_sector, 2);
        step(); step();
        check("t5_second", wb_sector, 61);
        step(); step();
        check("t5_done", flush_done, 1);
        wb_ready = 1'b0;

        // 6. reset during an offer
        write_sector(1, 1); write_sector(9, 1); write_sector(40, 1);
        flush_req = 1'b1; step(); flush_req = 1'b0; step();
        check("t6_offer", wb_valid, 1);
        check("t6_s1", wb_sector, 1);
        reset = 1'b1; step(); reset = 1'b0;
        check("t6_v", wb_valid, 0);
        check("t6_busy", flush_busy, 0);
        check("t6_bitmap", dirty_sectors, 64'h0);
        check("t6_clean", all_clean, 1);
        flush_req = 1'b1; step(); flush_req = 1'b0; step();
        check("t6_done", flush_done, 1);
        check("t6_nooffer", wb_valid, 0);

        // 7. accept plus a clear of a different sector nets -2
        write_sector(10, 1); write_sector(20, 1);
        check("t7_cnt2", dirty_count, 2);
        flush_req = 1'b1; step(); flush_req = 1'b0; step();
        check("t7_s10", wb_sector, 10);
        wb_ready = 1'b1; en = 1'b1; saddr = 20; d = 1'b0;
        step();
        en = 1'b0; wb_ready = 1'b0;
        check("t7_cnt0", dirty_count, 0);
        check("t7_bitmap", dirty_sectors, 64'h0);
        step();
        check("t7_done", flush_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dirty_sector_tracker
